// File: rtl/mem_io_bus_ctrl.sv
// Two-master arbiter and address decoder for the shared data-memory / memory-mapped I/O bus.
// Optional I/O wait timeout is compiled in when BUS_TIMEOUT_EN is defined.
module mem_io_bus_ctrl #(
  parameter logic [31:0] MEM_TOP  = 32'd32764,
  parameter logic [31:0] IO1_ADDR = 32'd32768,
  parameter logic [31:0] IO2_ADDR = 32'd32772,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        bus_err,
  output logic [31:0] bus_rdata,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  output logic        memwrite,
  output logic        memread,
  input  logic [31:0] mem_rdata,
  output logic        io1_write,
  output logic        io1_read,
  output logic        io2_write,
  output logic        io2_read,
  input  logic        io1_ready,
  input  logic        io2_ready,
  input  logic [31:0] io1_rdata,
  input  logic [31:0] io2_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  typedef enum logic [1:0] {T_MEM, T_IO1, T_IO2, T_NONE} tgt_t;

  state_t      r_state, w_state_nxt;
  tgt_t        r_tgt, w_tgt_nxt, w_dec;
  logic        r_gnt_m1, w_gnt_m1_nxt;
  logic        r_last_m1;
  logic        r_we, w_we_nxt;
  logic [31:0] r_dev_addr, w_addr_nxt;
  logic [31:0] r_dev_wdata, w_wdata_nxt;
  logic        w_sel_m1;
  logic [31:0] w_sel_addr;
  logic        w_io_ready;
  logic [31:0] w_io_rdata;
  logic        w_timeout;
  logic        w_resp_err;
  logic [31:0] w_resp_rdata;
  logic        w_resp, w_acc;

  logic        r_m0_ack, r_m1_ack, r_bus_err;
  logic [31:0] r_bus_rdata;
  logic        r_memwrite, r_memread;
  logic        r_io1_write, r_io1_read, r_io2_write, r_io2_read;

  // Round-robin: on a tie, m1 wins only if m0 was the last master served.
  always_comb begin
    w_sel_m1   = m1_req && (!m0_req || !r_last_m1);
    w_sel_addr = w_sel_m1 ? m1_addr : m0_addr;
  end

  always_comb begin
    w_dec = T_NONE;
    if (w_sel_addr <= MEM_TOP && w_sel_addr[1:0] == 2'b00) begin
      w_dec = T_MEM;
    end else if (w_sel_addr == IO1_ADDR) begin
      w_dec = T_IO1;
    end else if (w_sel_addr == IO2_ADDR) begin
      w_dec = T_IO2;
    end
  end

  always_comb begin
    w_io_ready = 1'b0;
    w_io_rdata = '0;
    if (r_tgt == T_IO1) begin
      w_io_ready = io1_ready;
      w_io_rdata = io1_rdata;
    end else if (r_tgt == T_IO2) begin
      w_io_ready = io2_ready;
      w_io_rdata = io2_rdata;
    end
  end

`ifdef BUS_TIMEOUT_EN
  logic [15:0] r_wait;

  // Counts completed ACCESS cycles of the current I/O wait; clears on leaving ACCESS.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait <= '0;
    end else if (r_state == S_ACCESS && w_state_nxt == S_ACCESS) begin
      r_wait <= r_wait + 16'd1;
    end else begin
      r_wait <= '0;
    end
  end

  assign w_timeout = (r_wait == 16'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_tgt_nxt    = r_tgt;
    w_gnt_m1_nxt = r_gnt_m1;
    w_we_nxt     = r_we;
    w_addr_nxt   = r_dev_addr;
    w_wdata_nxt  = r_dev_wdata;
    w_resp_err   = 1'b0;
    w_resp_rdata = '0;
    unique case (r_state)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          w_gnt_m1_nxt = w_sel_m1;
          w_we_nxt     = w_sel_m1 ? m1_we : m0_we;
          w_addr_nxt   = w_sel_addr;
          w_wdata_nxt  = w_sel_m1 ? m1_wdata : m0_wdata;
          w_tgt_nxt    = w_dec;
          if (w_dec == T_NONE) begin
            w_state_nxt = S_RESP;
            w_resp_err  = 1'b1;
          end else begin
            w_state_nxt = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (r_tgt == T_MEM) begin
          w_state_nxt  = S_RESP;
          w_resp_rdata = r_we ? '0 : mem_rdata;
        end else if (w_io_ready) begin
          // Ready takes priority over a timeout reached on the same edge.
          w_state_nxt  = S_RESP;
          w_resp_rdata = r_we ? '0 : w_io_rdata;
        end else if (w_timeout) begin
          w_state_nxt = S_RESP;
          w_resp_err  = 1'b1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state decision so they align with the state they describe.
  always_comb begin
    w_resp = (w_state_nxt == S_RESP);
    w_acc  = (w_state_nxt == S_ACCESS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tgt       <= T_NONE;
      r_gnt_m1    <= 1'b0;
      r_last_m1   <= 1'b1;
      r_we        <= 1'b0;
      r_dev_addr  <= '0;
      r_dev_wdata <= '0;
      r_m0_ack    <= 1'b0;
      r_m1_ack    <= 1'b0;
      r_bus_err   <= 1'b0;
      r_bus_rdata <= '0;
      r_memwrite  <= 1'b0;
      r_memread   <= 1'b0;
      r_io1_write <= 1'b0;
      r_io1_read  <= 1'b0;
      r_io2_write <= 1'b0;
      r_io2_read  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tgt       <= w_tgt_nxt;
      r_gnt_m1    <= w_gnt_m1_nxt;
      r_we        <= w_we_nxt;
      r_dev_addr  <= w_addr_nxt;
      r_dev_wdata <= w_wdata_nxt;
      if (r_state == S_RESP) begin
        r_last_m1 <= r_gnt_m1;
      end
      r_m0_ack    <= w_resp && !w_gnt_m1_nxt;
      r_m1_ack    <= w_resp && w_gnt_m1_nxt;
      r_bus_err   <= w_resp && w_resp_err;
      r_bus_rdata <= w_resp ? w_resp_rdata : '0;
      r_memwrite  <= w_acc && (w_tgt_nxt == T_MEM) && w_we_nxt;
      r_memread   <= w_acc && (w_tgt_nxt == T_MEM) && !w_we_nxt;
      r_io1_write <= w_acc && (w_tgt_nxt == T_IO1) && w_we_nxt;
      r_io1_read  <= w_acc && (w_tgt_nxt == T_IO1) && !w_we_nxt;
      r_io2_write <= w_acc && (w_tgt_nxt == T_IO2) && w_we_nxt;
      r_io2_read  <= w_acc && (w_tgt_nxt == T_IO2) && !w_we_nxt;
    end
  end

  assign m0_ack    = r_m0_ack;
  assign m1_ack    = r_m1_ack;
  assign bus_err   = r_bus_err;
  assign bus_rdata = r_bus_rdata;
  assign dev_addr  = r_dev_addr;
  assign dev_wdata = r_dev_wdata;
  assign memwrite  = r_memwrite;
  assign memread   = r_memread;
  assign io1_write = r_io1_write;
  assign io1_read  = r_io1_read;
  assign io2_write = r_io2_write;
  assign io2_read  = r_io2_read;

endmodule

// File: tb/tb_mem_io_bus_ctrl.sv
// Directed self-checking bench for mem_io_bus_ctrl; timeout expectations follow BUS_TIMEOUT_EN.
module tb_mem_io_bus_ctrl;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack, bus_err;
  logic [31:0] bus_rdata, dev_addr, dev_wdata;
  logic        memwrite, memread;
  logic [31:0] mem_rdata;
  logic        io1_write, io1_read, io2_write, io2_read;
  logic        io1_ready, io2_ready;
  logic [31:0] io1_rdata, io2_rdata;

  int n_cmp;
  int n_fail;

  // Observations gathered by run_window (offsets relative to the request cycle).
  int          n_strb [6];
  int          n_multi;
  int          first_strb;
  logic [31:0] obs_addr, obs_wdata;
  int          ack0_cyc, ack1_cyc, ack0_n, ack1_n;
  logic        ack_err;
  logic [31:0] ack_rdata;

  mem_io_bus_ctrl #(
    .MEM_TOP (32'd32764),
    .IO1_ADDR(32'd32768),
    .IO2_ADDR(32'd32772),
    .TIMEOUT (15)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack),
    .bus_err(bus_err), .bus_rdata(bus_rdata), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .memwrite(memwrite), .memread(memread), .mem_rdata(mem_rdata),
    .io1_write(io1_write), .io1_read(io1_read), .io2_write(io2_write), .io2_read(io2_read),
    .io1_ready(io1_ready), .io2_ready(io2_ready), .io1_rdata(io1_rdata), .io2_rdata(io2_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // Runs ncyc cycles starting at the request cycle; drops a master's req the cycle after its ack.
  // rdyN_at: cycle offset from which ioN_ready is high (-1 = never).
  task automatic run_window(input int ncyc, input int rdy1_at, input int rdy2_at);
    logic [5:0] sv;
    logic       a0, a1;
    for (int b = 0; b < 6; b++) n_strb[b] = 0;
    n_multi = 0; first_strb = -1; obs_addr = '0; obs_wdata = '0;
    ack0_cyc = -1; ack1_cyc = -1; ack0_n = 0; ack1_n = 0; ack_err = 1'b0; ack_rdata = '0;
    io1_ready = (rdy1_at == 0);
    io2_ready = (rdy2_at == 0);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      sv = {memwrite, memread, io1_write, io1_read, io2_write, io2_read};
      for (int b = 0; b < 6; b++) if (sv[b]) n_strb[b]++;
      if ($countones(sv) > 1) n_multi++;
      if (sv != 6'b0 && first_strb < 0) begin
        first_strb = i; obs_addr = dev_addr; obs_wdata = dev_wdata;
      end
      a0 = m0_ack; a1 = m1_ack;
      if (a0) begin
        if (ack0_n == 0) ack0_cyc = i;
        ack0_n++; ack_err = bus_err; ack_rdata = bus_rdata;
      end
      if (a1) begin
        if (ack1_n == 0) ack1_cyc = i;
        ack1_n++; ack_err = bus_err; ack_rdata = bus_rdata;
      end
      @(posedge clk); #1;
      if (a0) m0_req = 1'b0;
      if (a1) m1_req = 1'b0;
      io1_ready = (rdy1_at >= 0 && i + 1 >= rdy1_at);
      io2_ready = (rdy2_at >= 0 && i + 1 >= rdy2_at);
    end
    io1_ready = 1'b0;
    io2_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if ({m0_ack, m1_ack, bus_err} !== 3'b000) begin
      n_fail++; $display("FAIL rst_ack_err: got %b exp 000", {m0_ack, m1_ack, bus_err});
    end
    n_cmp++;
    if ({memwrite, memread, io1_write, io1_read, io2_write, io2_read} !== 6'b0) begin
      n_fail++; $display("FAIL rst_strobes: got %b exp 000000",
                         {memwrite, memread, io1_write, io1_read, io2_write, io2_read});
    end
    n_cmp++;
    if ({bus_rdata, dev_addr, dev_wdata} !== 96'h0) begin
      n_fail++; $display("FAIL rst_data: got %h %h %h exp all 0", bus_rdata, dev_addr, dev_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({m0_ack, m1_ack, memwrite, memread} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_release_idle: got %b exp 0000", {m0_ack, m1_ack, memwrite, memread});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mem_write();
    m0_we = 1'b1; m0_addr = 32'h100; m0_wdata = 32'hDEADBEEF; m0_req = 1'b1;
    run_window(5, -1, -1);
    n_cmp++;
    if (n_strb[5] !== 1 || first_strb !== 1) begin
      n_fail++; $display("FAIL wr_memwrite: got cycles=%0d first=%0d exp 1/1", n_strb[5], first_strb);
    end
    n_cmp++;
    if (obs_addr !== 32'h100 || obs_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wr_dev_bus: got %h/%h exp 00000100/deadbeef", obs_addr, obs_wdata);
    end
    n_cmp++;
    if (ack0_cyc !== 2 || ack0_n !== 1 || ack1_n !== 0) begin
      n_fail++; $display("FAIL wr_ack: got cyc=%0d n0=%0d n1=%0d exp 2/1/0", ack0_cyc, ack0_n, ack1_n);
    end
    n_cmp++;
    if (ack_err !== 1'b0 || ack_rdata !== 32'h0) begin
      n_fail++; $display("FAIL wr_resp: got err=%b rdata=%h exp 0/0", ack_err, ack_rdata);
    end
    n_cmp++;
    if (n_strb[4] + n_strb[3] + n_strb[2] + n_strb[1] + n_strb[0] !== 0) begin
      n_fail++; $display("FAIL wr_other_strobes: got %0d exp 0", n_strb[4] + n_strb[3] + n_strb[2] + n_strb[1] + n_strb[0]);
    end
  endtask

  task automatic test_mem_read();
    mem_rdata = 32'h12345678;
    m1_we = 1'b0; m1_addr = 32'h200; m1_wdata = 32'hFFFF0000; m1_req = 1'b1;
    run_window(5, -1, -1);
    n_cmp++;
    if (n_strb[4] !== 1 || n_strb[5] !== 0 || obs_addr !== 32'h200) begin
      n_fail++; $display("FAIL rd_memread: got rd=%0d wr=%0d addr=%h exp 1/0/00000200", n_strb[4], n_strb[5], obs_addr);
    end
    n_cmp++;
    if (ack1_cyc !== 2 || ack0_n !== 0 || ack_rdata !== 32'h12345678 || ack_err !== 1'b0) begin
      n_fail++; $display("FAIL rd_ack: got cyc=%0d n0=%0d rdata=%h err=%b exp 2/0/12345678/0",
                         ack1_cyc, ack0_n, ack_rdata, ack_err);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    mem_rdata = 32'hA5A5A5A5;
    m0_we = 1'b0; m0_addr = 32'h10; m1_we = 1'b0; m1_addr = 32'h20;
    m0_req = 1'b1; m1_req = 1'b1;
    run_window(8, -1, -1);
    n_cmp++;
    if (ack0_cyc !== 2 || ack1_cyc !== 5) begin
      n_fail++; $display("FAIL rr_first_tie: got m0=%0d m1=%0d exp 2/5", ack0_cyc, ack1_cyc);
    end
    n_cmp++;
    if (n_strb[4] !== 2 || n_multi !== 0) begin
      n_fail++; $display("FAIL rr_memread_count: got %0d multi=%0d exp 2/0", n_strb[4], n_multi);
    end
    // m0 served alone, so the next tie must go to m1
    m0_req = 1'b1;
    run_window(4, -1, -1);
    m0_req = 1'b1; m1_req = 1'b1;
    run_window(8, -1, -1);
    n_cmp++;
    if (ack1_cyc !== 2 || ack0_cyc !== 5) begin
      n_fail++; $display("FAIL rr_alternate: got m1=%0d m0=%0d exp 2/5", ack1_cyc, ack0_cyc);
    end
  endtask

  task automatic test_io_wait();
    io2_rdata = 32'h55;
    m1_we = 1'b0; m1_addr = 32'd32772; m1_req = 1'b1;
    run_window(9, -1, 5);
    n_cmp++;
    if (n_strb[0] !== 5 || first_strb !== 1 || n_strb[4] !== 0) begin
      n_fail++; $display("FAIL io_wait_strobe: got io2_read=%0d first=%0d memread=%0d exp 5/1/0",
                         n_strb[0], first_strb, n_strb[4]);
    end
    n_cmp++;
    if (ack1_cyc !== 6 || ack_rdata !== 32'h55 || ack_err !== 1'b0) begin
      n_fail++; $display("FAIL io_wait_ack: got cyc=%0d rdata=%h err=%b exp 6/00000055/0", ack1_cyc, ack_rdata, ack_err);
    end
  endtask

  task automatic test_io_write_ready();
    io1_rdata = 32'hCAFE0001;
    m0_we = 1'b1; m0_addr = 32'd32768; m0_wdata = 32'h77; m0_req = 1'b1;
    run_window(5, 0, -1);
    n_cmp++;
    if (n_strb[3] !== 1 || n_strb[2] !== 0 || obs_wdata !== 32'h77) begin
      n_fail++; $display("FAIL io1_wr_strobe: got wr=%0d rd=%0d wdata=%h exp 1/0/00000077", n_strb[3], n_strb[2], obs_wdata);
    end
    n_cmp++;
    if (ack0_cyc !== 2 || ack_rdata !== 32'h0 || ack_err !== 1'b0) begin
      n_fail++; $display("FAIL io1_wr_ack: got cyc=%0d rdata=%h err=%b exp 2/0/0", ack0_cyc, ack_rdata, ack_err);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] addrs [2];
    addrs[0] = 32'd32776;
    addrs[1] = 32'd6;
    mem_rdata = 32'hBBBBBBBB;
    for (int k = 0; k < 2; k++) begin
      m0_we = 1'b0; m0_addr = addrs[k]; m0_req = 1'b1;
      run_window(4, 0, 0);
      n_cmp++;
      if (first_strb !== -1) begin
        n_fail++; $display("FAIL unmapped_strobe[%0d]: got first strobe at %0d exp none", k, first_strb);
      end
      n_cmp++;
      if (ack0_cyc !== 1 || ack0_n !== 1 || ack_err !== 1'b1 || ack_rdata !== 32'h0) begin
        n_fail++; $display("FAIL unmapped_ack[%0d]: got cyc=%0d n=%0d err=%b rdata=%h exp 1/1/1/0",
                           k, ack0_cyc, ack0_n, ack_err, ack_rdata);
      end
    end
  endtask

  task automatic test_mem_top();
    mem_rdata = 32'h0BADF00D;
    m1_we = 1'b0; m1_addr = 32'd32764; m1_req = 1'b1;
    run_window(5, -1, -1);
    n_cmp++;
    if (n_strb[4] !== 1 || ack1_cyc !== 2 || ack_err !== 1'b0 || ack_rdata !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL mem_top: got rd=%0d cyc=%0d err=%b rdata=%h exp 1/2/0/0badf00d",
                         n_strb[4], ack1_cyc, ack_err, ack_rdata);
    end
  endtask

  task automatic test_timeout();
    io1_rdata = 32'h99;
    m0_we = 1'b0; m0_addr = 32'd32768; m0_req = 1'b1;
`ifdef BUS_TIMEOUT_EN
    run_window(20, -1, -1);
    n_cmp++;
    if (n_strb[2] !== 15 || ack0_cyc !== 16 || ack_err !== 1'b1 || ack_rdata !== 32'h0) begin
      n_fail++; $display("FAIL timeout_expire: got rd=%0d cyc=%0d err=%b rdata=%h exp 15/16/1/0",
                         n_strb[2], ack0_cyc, ack_err, ack_rdata);
    end
    m0_req = 1'b1;
    run_window(20, 15, -1);
    n_cmp++;
    if (n_strb[2] !== 15 || ack0_cyc !== 16 || ack_err !== 1'b0 || ack_rdata !== 32'h99) begin
      n_fail++; $display("FAIL timeout_ready_wins: got rd=%0d cyc=%0d err=%b rdata=%h exp 15/16/0/00000099",
                         n_strb[2], ack0_cyc, ack_err, ack_rdata);
    end
`else
    run_window(100, -1, -1);
    n_cmp++;
    if (ack0_n !== 0 || ack1_n !== 0 || n_strb[2] !== 99) begin
      n_fail++; $display("FAIL no_timeout_wait: got acks=%0d/%0d io1_read=%0d exp 0/0/99", ack0_n, ack1_n, n_strb[2]);
    end
    do_reset();
`endif
  endtask

  task automatic test_reset_abort();
    m1_we = 1'b0; m1_addr = 32'd32772; m1_req = 1'b1;
    io2_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++;
    if (io2_read !== 1'b1) begin
      n_fail++; $display("FAIL abort_pre_strobe: got %b exp 1", io2_read);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    m1_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({memwrite, memread, io1_write, io1_read, io2_write, io2_read, m0_ack, m1_ack} !== 8'b0) begin
      n_fail++; $display("FAIL abort_strobes: got %b exp 00000000",
                         {memwrite, memread, io1_write, io1_read, io2_write, io2_read, m0_ack, m1_ack});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rdata = 32'h31415926;
    m0_we = 1'b0; m0_addr = 32'h40; m0_req = 1'b1;
    run_window(5, -1, -1);
    n_cmp++;
    if (ack0_cyc !== 2 || ack1_n !== 0 || ack_rdata !== 32'h31415926 || n_strb[4] !== 1) begin
      n_fail++; $display("FAIL abort_recover: got cyc=%0d n1=%0d rdata=%h rd=%0d exp 2/0/31415926/1",
                         ack0_cyc, ack1_n, ack_rdata, n_strb[4]);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    mem_rdata = '0; io1_ready = 1'b0; io2_ready = 1'b0; io1_rdata = '0; io2_rdata = '0;
    test_reset();
    test_mem_write();
    test_mem_read();
    test_round_robin();
    test_io_wait();
    test_io_write_ready();
    test_unmapped();
    test_mem_top();
    test_timeout();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
